// File: rtl/instr_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue_if
//   Bundle of the loader, redirect, decode-pop and queue-status signals of
//   instr_fetch_queue. Clock and reset are kept as plain module ports.
//
//   master : loader/decode side (drives load, redirect, pop; sees queue)
//   slave  : the fetch queue itself
//
//   load_en/load_addr/load_data : store write port (stalls fetch)
//   redirect/redirect_pc        : flush queue and restart fetch
//   pop_count                   : instructions consumed this cycle (0..2)
//   instruction/instr_pc/instr_valid : queue head
//   next_instruction/next_valid      : entry behind the head
//   fetch_pc                    : next address to be fetched
//   occupancy                   : entries held
//   pop_err                     : pulse, pop asked for more than was held
// ---------------------------------------------------------------------------
interface instr_fetch_queue_if #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int Q_DEPTH = 4
);
  localparam int OCC_W = $clog2(Q_DEPTH) + 1;

  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [1:0]        pop_count;
  logic [DATA_W-1:0] instruction;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic [DATA_W-1:0] next_instruction;
  logic              next_valid;
  logic [ADDR_W-1:0] fetch_pc;
  logic [OCC_W-1:0]  occupancy;
  logic              pop_err;

  modport master (
    output load_en, load_addr, load_data, redirect, redirect_pc, pop_count,
    input  instruction, instr_pc, instr_valid, next_instruction, next_valid,
           fetch_pc, occupancy, pop_err
  );

  modport slave (
    input  load_en, load_addr, load_data, redirect, redirect_pc, pop_count,
    output instruction, instr_pc, instr_valid, next_instruction, next_valid,
           fetch_pc, occupancy, pop_err
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//   Writable instruction store with a loader port, an internal fetch PC and
//   a prefetch FIFO that presents the head instruction and the one behind it
//   to decode. Decode consumes 0, 1 or 2 instructions per cycle; a redirect
//   flushes the FIFO and restarts fetch at a new PC.
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset (store contents are kept)
//     bus   : instr_fetch_queue_if.slave (see interface header)
//
//   Edge priority: redirect > load > pop/fetch. All outputs come from
//   registers only; there is no input-to-output combinational path.
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 32,
  parameter int Q_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_queue_if.slave   bus
);
  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  // Index width of the store; addresses at or beyond DEPTH never index it.
  localparam int SA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // -------------------------------------------------------------------------
  // Instruction store: written by the loader, read combinationally at
  // fetch_pc. Never reset so a program survives rst_n.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] store_mem [DEPTH];
  logic [DATA_W-1:0] store_rd;
  logic              store_we;
  logic              fetch_in_range;

  // -------------------------------------------------------------------------
  // Prefetch FIFO: payload slots plus head/tail pointers and occupancy.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] q_data [Q_DEPTH];
  logic [ADDR_W-1:0] q_pc   [Q_DEPTH];

  logic [PTR_W-1:0]  head_reg,      head_next;
  logic [PTR_W-1:0]  tail_reg,      tail_next;
  logic [OCC_W-1:0]  occupancy_reg, occupancy_next;
  logic [ADDR_W-1:0] fetch_pc_reg,  fetch_pc_next;
  logic              pop_err_reg,   pop_err_next;

  logic [1:0]        req_pop;
  logic [OCC_W-1:0]  req_ext;
  logic [OCC_W-1:0]  eff_pop;
  logic [OCC_W-1:0]  after_pop;
  logic              pop_over;
  logic              push;
  logic [PTR_W-1:0]  next_ptr;

  // Loads lose to a redirect on the same edge, and out-of-range loads drop.
  assign store_we = bus.load_en && !bus.redirect &&
                    (32'(bus.load_addr) < 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst_n && store_we) begin
      store_mem[bus.load_addr[SA_W-1:0]] <= bus.load_data;
    end
  end

  // Unimplemented addresses behave as NOPs (zero words).
  assign fetch_in_range = (32'(fetch_pc_reg) < 32'(DEPTH));
  assign store_rd       = fetch_in_range ? store_mem[fetch_pc_reg[SA_W-1:0]]
                                         : '0;

  // -------------------------------------------------------------------------
  // Pop / push arithmetic
  // -------------------------------------------------------------------------
  always_comb begin
    // A request of 3 is treated as 2; the pop is clipped to what is held.
    req_pop   = (bus.pop_count == 2'd3) ? 2'd2 : bus.pop_count;
    req_ext   = OCC_W'(req_pop);
    pop_over  = (req_ext > occupancy_reg);
    eff_pop   = pop_over ? occupancy_reg : req_ext;
    after_pop = occupancy_reg - eff_pop;
    // Room is judged after this cycle's pop, so a full queue can still
    // accept a new word on the same edge decode drains it.
    push      = !bus.redirect && !bus.load_en &&
                (after_pop < OCC_W'(Q_DEPTH));
  end

  always_comb begin
    head_next      = head_reg;
    tail_next      = tail_reg;
    occupancy_next = occupancy_reg;
    fetch_pc_next  = fetch_pc_reg;
    pop_err_next   = 1'b0;
    if (bus.redirect) begin
      head_next      = '0;
      tail_next      = '0;
      occupancy_next = '0;
      fetch_pc_next  = bus.redirect_pc;
    end else begin
      // Pointers are PTR_W bits wide and Q_DEPTH is a power of two, so the
      // additions wrap around the ring naturally.
      head_next      = head_reg + PTR_W'(eff_pop);
      tail_next      = tail_reg + PTR_W'(push);
      occupancy_next = after_pop + OCC_W'(push);
      pop_err_next   = pop_over;
      if (push) begin
        fetch_pc_next = fetch_pc_reg + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      occupancy_reg <= '0;
      fetch_pc_reg  <= '0;
      pop_err_reg   <= 1'b0;
    end else begin
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      occupancy_reg <= occupancy_next;
      fetch_pc_reg  <= fetch_pc_next;
      pop_err_reg   <= pop_err_next;
    end
  end

  // Payload slots need no reset: they are only visible through the
  // occupancy-gated outputs below.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      q_data[tail_reg] <= store_rd;
      q_pc[tail_reg]   <= fetch_pc_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: derived from queue registers only, zero when not valid.
  // -------------------------------------------------------------------------
  assign next_ptr             = head_reg + PTR_W'(1);
  assign bus.instr_valid      = (occupancy_reg != '0);
  assign bus.next_valid       = (occupancy_reg >= OCC_W'(2));
  assign bus.instruction      = bus.instr_valid ? q_data[head_reg] : '0;
  assign bus.instr_pc         = bus.instr_valid ? q_pc[head_reg]   : '0;
  assign bus.next_instruction = bus.next_valid  ? q_data[next_ptr] : '0;
  assign bus.fetch_pc         = fetch_pc_reg;
  assign bus.occupancy        = occupancy_reg;
  assign bus.pop_err          = pop_err_reg;

endmodule
